// File: rtl/osd_trace_pkg.sv
// Shared definitions for the trace sample buffer: overflow counter width,
// the entry layout, and the saturating drop-count increment.
package osd_trace_pkg;

  localparam int OVF_CNT_WIDTH = 10;
  localparam int MAX_WIDTH = 64;
  localparam logic [OVF_CNT_WIDTH-1:0] OVF_CNT_MAX = '1;

  typedef struct packed {
    logic                 ovf;
    logic [MAX_WIDTH-1:0] data;
  } trace_entry_t;

  // 1023 means "1023 or more lost", so the count sticks there.
  function automatic logic [OVF_CNT_WIDTH-1:0] sat_add(
    input logic [OVF_CNT_WIDTH-1:0] cnt,
    input logic                     inc
  );
    logic [OVF_CNT_WIDTH:0] sum;
    sum = {1'b0, cnt} + {{OVF_CNT_WIDTH{1'b0}}, inc};
    return sum[OVF_CNT_WIDTH] ? OVF_CNT_MAX : sum[OVF_CNT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/osd_trace_fifo.sv
// Generic first-word-fall-through FIFO. A push is accepted while full when
// the same cycle also pops, so fill stays at DEPTH.
module osd_trace_fifo #(
  parameter int DATA_W = 17,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       fill;
  logic              do_pop;
  logic              do_push;

  assign empty   = (fill == '0);
  assign full    = (fill == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/osd_trace_sample_buffer.sv
// Trace sample capture buffer: drops samples while the FIFO is full, counts
// them, and inserts an in-order overflow record once space frees up.
module osd_trace_sample_buffer
  import osd_trace_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] sample_data,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] trace_data,
  output logic             trace_overflow,
  output logic             trace_valid,
  input  logic             trace_ready
);

  logic [OVF_CNT_WIDTH-1:0] ovf_cnt;
  logic [OVF_CNT_WIDTH-1:0] ovf_nxt;
  logic [WIDTH:0]           wr_data;
  logic [WIDTH:0]           rd_data;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic                     space;

  assign pop   = trace_valid && trace_ready;
  assign space = !full || pop;

  always_comb begin
    push    = 1'b0;
    wr_data = '0;
    ovf_nxt = ovf_cnt;
    if (enable) begin
      if (ovf_cnt == '0) begin
        if (sample_valid) begin
          if (space) begin
            push    = 1'b1;
            wr_data = {1'b0, sample_data};
          end else begin
            ovf_nxt = OVF_CNT_WIDTH'(1);
          end
        end
      end else if (!space) begin
        if (sample_valid) ovf_nxt = sat_add(ovf_cnt, 1'b1);
      end else begin
        // The sample arriving with the record slot is dropped and counted.
        push    = 1'b1;
        wr_data = {1'b1, WIDTH'(sat_add(ovf_cnt, sample_valid))};
        ovf_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_cnt <= '0;
    else     ovf_cnt <= ovf_nxt;
  end

  osd_trace_fifo #(
    .DATA_W (WIDTH + 1),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  assign trace_valid    = !empty;
  assign trace_overflow = !empty && rd_data[WIDTH];
  assign trace_data     = empty ? '0 : rd_data[WIDTH-1:0];

endmodule

// File: tb/tb_osd_trace_sample_buffer.sv
// Directed bench for osd_trace_sample_buffer: a streaming vector table plus
// hand-written fill/drop, saturation, full push+pop and async reset sequences.
module tb_osd_trace_sample_buffer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [WIDTH-1:0] sample_data;
  logic             sample_valid;
  logic [WIDTH-1:0] trace_data;
  logic             trace_overflow;
  logic             trace_valid;
  logic             trace_ready;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic        sv;
    logic [15:0] din;
    logic        rdy;
    logic        exp_valid;
    logic        exp_ovf;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [18];

  osd_trace_sample_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .sample_data    (sample_data),
    .sample_valid   (sample_valid),
    .trace_data     (trace_data),
    .trace_overflow (trace_overflow),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_out(input string name, input logic v, input logic o, input logic [15:0] d);
    check({name, ".valid"}, 32'(trace_valid), 32'(v));
    check({name, ".ovf"},   32'(trace_overflow), 32'(o));
    check({name, ".data"},  32'(trace_data), 32'(d));
  endtask

  task automatic drive(input logic sv, input logic [15:0] d, input logic rdy);
    sample_valid = sv;
    sample_data  = d;
    trace_ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Streaming table: sample i+1 driven at step i, visible at step i+1.
    for (int i = 0; i < 18; i++) begin
      vecs[i].sv        = (i < 16);
      vecs[i].din       = (i < 16) ? 16'(i + 1) : 16'h0;
      vecs[i].rdy       = 1'b1;
      vecs[i].exp_valid = (i >= 1 && i <= 16);
      vecs[i].exp_ovf   = 1'b0;
      vecs[i].exp_data  = (i >= 1 && i <= 16) ? 16'(i) : 16'h0;
    end

    rst    = 1'b1;
    enable = 1'b1;
    drive(1'b0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 1'b0, 16'h0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      expect_out($sformatf("stream[%0d]", i), vecs[i].exp_valid, vecs[i].exp_ovf, vecs[i].exp_data);
      drive(vecs[i].sv, vecs[i].din, vecs[i].rdy);
      tick();
    end

    // Fill and drop: 11 samples into 8 slots, 3 dropped.
    for (int i = 0; i < 11; i++) begin
      if (i > 0) expect_out($sformatf("hold_a[%0d]", i), 1'b1, 1'b0, 16'hA000);
      drive(1'b1, 16'hA000 + 16'(i), 1'b0);
      tick();
    end
    drive(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      expect_out($sformatf("drain_a[%0d]", i), 1'b1, 1'b0, 16'hA000 + 16'(i));
      tick();
    end
    expect_out("ovf_a", 1'b1, 1'b1, 16'd3);
    tick();
    expect_out("empty_a", 1'b0, 1'b0, 16'h0);

    // Drop count includes the sample arriving in the insertion cycle.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'hB000 + 16'(i), 1'b0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'hB100 + 16'(i), 1'b0);
      tick();
    end
    expect_out("ins_b_head", 1'b1, 1'b0, 16'hB000);
    drive(1'b1, 16'hBBBB, 1'b1);
    tick();
    drive(1'b0, 16'h0, 1'b1);
    for (int i = 1; i < 8; i++) begin
      expect_out($sformatf("drain_b[%0d]", i), 1'b1, 1'b0, 16'hB000 + 16'(i));
      tick();
    end
    expect_out("ovf_b", 1'b1, 1'b1, 16'd3);
    tick();
    expect_out("empty_b", 1'b0, 1'b0, 16'h0);

    // Saturation: 1500 drops report as 1023.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'hC000 + 16'(i), 1'b0);
      tick();
    end
    for (int i = 0; i < 1500; i++) begin
      drive(1'b1, 16'hCC00, 1'b0);
      tick();
    end
    drive(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      expect_out($sformatf("drain_c[%0d]", i), 1'b1, 1'b0, 16'hC000 + 16'(i));
      tick();
    end
    expect_out("ovf_c", 1'b1, 1'b1, 16'd1023);
    tick();
    expect_out("empty_c", 1'b0, 1'b0, 16'h0);

    // Full push+pop for 20 cycles across pointer wrap, no drops.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'hD000 + 16'(i), 1'b0);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      expect_out($sformatf("pp_d[%0d]", k), 1'b1, 1'b0, 16'hD000 + 16'(k));
      drive(1'b1, 16'hD008 + 16'(k), 1'b1);
      tick();
    end
    drive(1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      expect_out($sformatf("drain_d[%0d]", k), 1'b1, 1'b0, 16'hD014 + 16'(k));
      tick();
    end
    expect_out("empty_d", 1'b0, 1'b0, 16'h0);

    // Async reset mid-drain with 5 entries buffered and ovf_cnt=4.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'hE000 + 16'(i), 1'b0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'hE100 + 16'(i), 1'b0);
      tick();
    end
    enable = 1'b0;
    drive(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("drain_e[%0d]", i), 1'b1, 1'b0, 16'hE000 + 16'(i));
      tick();
    end
    expect_out("pre_rst_e", 1'b1, 1'b0, 16'hE003);
    #1 rst = 1'b1;
    #1 expect_out("async_rst", 1'b0, 1'b0, 16'h0);
    #1 rst = 1'b0;
    drive(1'b1, 16'h0BAD, 1'b0);
    tick();
    expect_out("enable_off", 1'b0, 1'b0, 16'h0);
    enable = 1'b1;
    drive(1'b1, 16'h0C00, 1'b0);
    tick();
    expect_out("post_rst_c0", 1'b1, 1'b0, 16'h0C00);
    drive(1'b0, 16'h0, 1'b1);
    tick();
    expect_out("post_rst_empty", 1'b0, 1'b0, 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
